// File: rtl/life_grid_engine_pkg.sv
// Shared types and constants for the Life-like grid engine.
// FSM state encoding, neighbour-count width and the classic rule masks.
package life_grid_engine_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int         NBR_W    = 4;
  localparam logic [8:0] LIFE_B3  = 9'h008;
  localparam logic [8:0] LIFE_S23 = 9'h00C;

endpackage

// File: rtl/life_grid_engine_if.sv
// Row load and result readback streams of the grid engine.
// The host side drives as master, the engine consumes as slave.
interface life_grid_engine_if #(
  parameter int GRID_W = 16
) ();
  logic              load_valid;
  logic              load_ready;
  logic [GRID_W-1:0] load_row;
  logic              out_valid;
  logic              out_ready;
  logic [GRID_W-1:0] out_row;
  logic              out_last;

  modport master (
    output load_valid, load_row, out_ready,
    input  load_ready, out_valid, out_row, out_last
  );

  modport slave (
    input  load_valid, load_row, out_ready,
    output load_ready, out_valid, out_row, out_last
  );
endinterface

// File: rtl/life_grid_engine_rule_cell.sv
// One cell of the Life-like rule: counts eight neighbours and looks the
// count up in the birth or survive mask depending on the centre state.
module life_rule_cell
  import life_grid_engine_pkg::*;
(
  input  logic       center,
  input  logic [7:0] nbr,
  input  logic [8:0] birth,
  input  logic [8:0] survive,
  output logic       next
);

  logic [NBR_W-1:0] n;

  always_comb begin
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + NBR_W'(nbr[i]);
    end
    next = center ? survive[n] : birth[n];
  end

endmodule

// File: rtl/life_grid_engine.sv
// Multi-generation Life-like grid engine: loads a bit grid row by row,
// advances it one row per cycle for gen_count generations, streams it back.
module life_grid_engine
  import life_grid_engine_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [8:0]          cfg_birth,
  input  logic [8:0]          cfg_survive,
  input  logic                cfg_wrap,
  input  logic                start,
  input  logic [CNT_W-1:0]    gen_count,
  output logic                busy,
  output logic                done,
  life_grid_engine_if.slave   bus
);

  localparam int             RW       = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [RW-1:0]  LAST_ROW = RW'(GRID_H - 1);

  state_t             state_q, state_d;
  logic [RW-1:0]      load_ptr_q, load_ptr_d;
  logic [RW-1:0]      row_ptr_q, row_ptr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [8:0]         birth_q, birth_d;
  logic [8:0]         survive_q, survive_d;
  logic               wrap_q, wrap_d;
  logic               cur_sel_q, cur_sel_d;
  logic               done_q, done_d;
  logic [GRID_W-1:0]  bank_q [2][GRID_H];
  logic [GRID_W-1:0]  bank_d [2][GRID_H];

  logic [GRID_W-1:0]  row_up, row_mid, row_dn, next_row;
  logic [GRID_W+1:0]  pad_up, pad_mid, pad_dn;

  // Rows above/below the active row; off-grid rows read as zero unless wrapping.
  always_comb begin
    row_mid = bank_q[cur_sel_q][row_ptr_q];
    if (row_ptr_q == RW'(0)) begin
      row_up = wrap_q ? bank_q[cur_sel_q][LAST_ROW] : '0;
    end else begin
      row_up = bank_q[cur_sel_q][row_ptr_q - 1'b1];
    end
    if (row_ptr_q == LAST_ROW) begin
      row_dn = wrap_q ? bank_q[cur_sel_q][RW'(0)] : '0;
    end else begin
      row_dn = bank_q[cur_sel_q][row_ptr_q + 1'b1];
    end
    pad_up  = {wrap_q & row_up[0],  row_up,  wrap_q & row_up[GRID_W-1]};
    pad_mid = {wrap_q & row_mid[0], row_mid, wrap_q & row_mid[GRID_W-1]};
    pad_dn  = {wrap_q & row_dn[0],  row_dn,  wrap_q & row_dn[GRID_W-1]};
  end

  for (genvar c = 0; c < GRID_W; c++) begin : g_cell
    life_rule_cell u_cell (
      .center  (row_mid[c]),
      .nbr     ({pad_up[c+2], pad_up[c+1], pad_up[c],
                 pad_mid[c+2], pad_mid[c],
                 pad_dn[c+2], pad_dn[c+1], pad_dn[c]}),
      .birth   (birth_q),
      .survive (survive_q),
      .next    (next_row[c])
    );
  end

  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    row_ptr_d   = row_ptr_q;
    remaining_d = remaining_q;
    birth_d     = birth_q;
    survive_d   = survive_q;
    wrap_d      = wrap_q;
    cur_sel_d   = cur_sel_q;
    done_d      = 1'b0;
    bank_d      = bank_q;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          bank_d[cur_sel_q][load_ptr_q] = bus.load_row;
          load_ptr_d = (load_ptr_q == LAST_ROW) ? RW'(0) : load_ptr_q + 1'b1;
        end
        if (start) begin
          birth_d     = cfg_birth;
          survive_d   = cfg_survive;
          wrap_d      = cfg_wrap;
          remaining_d = gen_count;
          row_ptr_d   = '0;
          state_d     = (gen_count == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        bank_d[~cur_sel_q][row_ptr_q] = next_row;
        if (row_ptr_q == LAST_ROW) begin
          row_ptr_d   = '0;
          cur_sel_d   = ~cur_sel_q;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) state_d = DRAIN;
        end else begin
          row_ptr_d = row_ptr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (row_ptr_q == LAST_ROW) begin
            row_ptr_d = '0;
            state_d   = IDLE;
            done_d    = 1'b1;
          end else begin
            row_ptr_d = row_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      load_ptr_q  <= '0;
      row_ptr_q   <= '0;
      remaining_q <= '0;
      birth_q     <= '0;
      survive_q   <= '0;
      wrap_q      <= 1'b0;
      cur_sel_q   <= 1'b0;
      done_q      <= 1'b0;
      bank_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      load_ptr_q  <= load_ptr_d;
      row_ptr_q   <= row_ptr_d;
      remaining_q <= remaining_d;
      birth_q     <= birth_d;
      survive_q   <= survive_d;
      wrap_q      <= wrap_d;
      cur_sel_q   <= cur_sel_d;
      done_q      <= done_d;
      bank_q      <= bank_d;
    end
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DRAIN);
  assign bus.out_row    = (state_q == DRAIN) ? row_mid : '0;
  assign bus.out_last   = (state_q == DRAIN) && (row_ptr_q == LAST_ROW);
  assign busy           = (state_q != IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine on an 8x8 grid, checked against a cell-by-cell
// neighbour-counting model of the grid held in plain arrays.
module tb_life_grid_engine;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [8:0]    cfg_birth = 9'h008;
  logic [8:0]    cfg_survive = 9'h00C;
  logic          cfg_wrap = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] gen_count = '0;
  logic          busy, done;

  always #5 clk = ~clk;

  life_grid_engine_if #(.GRID_W(W)) bus ();

  life_grid_engine #(.GRID_W(W), .GRID_H(H), .CNT_W(CW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cfg_birth   (cfg_birth),
    .cfg_survive (cfg_survive),
    .cfg_wrap    (cfg_wrap),
    .start       (start),
    .gen_count   (gen_count),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mgrid [H];
  logic [W-1:0] stim  [H];
  int           mload_ptr = 0;

  logic [W-1:0] got_rows [H];
  logic [H-1:0] got_last;
  logic         got_done, got_busy, got_stable, got_early_done, got_lr_bad, got_timeout;
  int           got_k;

  // Reference: count live neighbours of every cell, then apply the masks.
  task automatic model_run(input int gens, input logic [8:0] b, input logic [8:0] s, input bit wr);
    logic [W-1:0] nx [H];
    for (int g = 0; g < gens; g++) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          int n;
          n = 0;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              int rr, cc;
              if (dr == 0 && dc == 0) continue;
              rr = r + dr;
              cc = c + dc;
              if (wr) begin
                rr = (rr + H) % H;
                cc = (cc + W) % W;
              end else if (rr < 0 || rr >= H || cc < 0 || cc >= W) begin
                continue;
              end
              n += int'(mgrid[rr][cc]);
            end
          end
          nx[r][c] = mgrid[r][c] ? s[n] : b[n];
        end
      end
      for (int r = 0; r < H; r++) mgrid[r] = nx[r];
    end
  endtask

  // Loads stim[] as 8 rows; optionally raises start with the last row.
  task automatic load_stim(input bit start_with_last, input int gens);
    for (int i = 0; i < H; i++) begin
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_row   = stim[i];
      if (start_with_last && i == H - 1) begin
        start     = 1'b1;
        gen_count = CW'(gens);
      end
      @(posedge clk);
      #1;
      bus.load_valid = 1'b0;
      start          = 1'b0;
      mgrid[mload_ptr] = stim[i];
      mload_ptr = (mload_ptr + 1) % H;
    end
  endtask

  task automatic do_start(input int gens);
    @(negedge clk);
    start     = 1'b1;
    gen_count = CW'(gens);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts whole cycles after the start edge until out_valid shows.
  task automatic wait_valid();
    got_k = 0;
    while (got_k < 2000) begin
      @(negedge clk);
      if (bus.out_valid) break;
      got_k++;
    end
  endtask

  // Accepts the 8 drained rows with the given ready duty (percent).
  task automatic collect(input int duty);
    int           idx, cyc;
    logic [W-1:0] prev_row;
    logic         prev_last, prev_stall;
    idx = 0; cyc = 0; prev_stall = 1'b0; prev_row = '0; prev_last = 1'b0;
    got_stable = 1'b1; got_early_done = 1'b0; got_lr_bad = 1'b0; got_last = '0;
    while (idx < H && cyc < 2000) begin
      bus.out_ready = ($urandom_range(99) < duty);
      if (done) got_early_done = 1'b1;
      if (bus.load_ready) got_lr_bad = 1'b1;
      if (prev_stall && (!bus.out_valid || bus.out_row !== prev_row || bus.out_last !== prev_last))
        got_stable = 1'b0;
      if (bus.out_valid) begin
        prev_row   = bus.out_row;
        prev_last  = bus.out_last;
        prev_stall = !bus.out_ready;
        if (bus.out_ready) begin
          got_rows[idx] = bus.out_row;
          got_last[idx] = bus.out_last;
          idx++;
        end
      end else begin
        prev_stall = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    got_timeout   = (idx < H);
    got_done      = done;
    got_busy      = busy;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, bus.out_valid, bus.out_last, done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000", {busy, bus.out_valid, bus.out_last, done});
    end
    total++;
    if (bus.out_row !== '0) begin
      bad++;
      $display("FAIL reset_out_row got=%h exp=00", bus.out_row);
    end
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (bus.load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_load_ready got=%b exp=1", bus.load_ready);
    end
    for (int r = 0; r < H; r++) mgrid[r] = '0;
    mload_ptr = 0;
  endtask

  task automatic test_blinker();
    logic [W-1:0] exp_row;
    cfg_birth = 9'h008; cfg_survive = 9'h00C; cfg_wrap = 1'b0;
    for (int g = 1; g <= 2; g++) begin
      for (int r = 0; r < H; r++) stim[r] = (r >= 2 && r <= 4) ? 8'h08 : 8'h00;
      load_stim(0, 0);
      do_start(g);
      wait_valid();
      total++;
      if (got_k !== g * H) begin
        bad++;
        $display("FAIL blinker_latency gen=%0d got=%0d exp=%0d", g, got_k, g * H);
      end
      collect(100);
      model_run(g, 9'h008, 9'h00C, 1'b0);
      for (int r = 0; r < H; r++) begin
        if (g == 1) exp_row = (r == 3) ? 8'h1C : 8'h00;
        else        exp_row = (r >= 2 && r <= 4) ? 8'h08 : 8'h00;
        total++;
        if (got_rows[r] !== exp_row) begin
          bad++;
          $display("FAIL blinker_row gen=%0d row=%0d got=%h exp=%h", g, r, got_rows[r], exp_row);
        end
      end
      total++;
      if (got_done !== 1'b1 || got_busy !== 1'b0) begin
        bad++;
        $display("FAIL blinker_done got=%b%b exp=10", got_done, got_busy);
      end
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] exp_row;
    cfg_birth = 9'h008; cfg_survive = 9'h00C;
    for (int w = 0; w < 2; w++) begin
      cfg_wrap = w[0];
      for (int r = 0; r < H; r++) stim[r] = (r == 0) ? 8'hFF : 8'h00;
      load_stim(0, 0);
      do_start(1);
      wait_valid();
      collect(100);
      model_run(1, 9'h008, 9'h00C, w[0]);
      for (int r = 0; r < H; r++) begin
        if (w == 0) exp_row = (r <= 1) ? 8'h7E : 8'h00;
        else        exp_row = (r <= 1 || r == 7) ? 8'hFF : 8'h00;
        total++;
        if (got_rows[r] !== exp_row) begin
          bad++;
          $display("FAIL edges_row wrap=%0d row=%0d got=%h exp=%h", w, r, got_rows[r], exp_row);
        end
      end
    end
  endtask

  task automatic test_gen0();
    for (int r = 0; r < H; r++) stim[r] = W'($urandom);
    load_stim(1, 0);
    wait_valid();
    total++;
    if (got_k !== 0) begin
      bad++;
      $display("FAIL gen0_latency got=%0d exp=0", got_k);
    end
    collect(100);
    for (int r = 0; r < H; r++) begin
      total++;
      if (got_rows[r] !== stim[r]) begin
        bad++;
        $display("FAIL gen0_echo row=%0d got=%h exp=%h", r, got_rows[r], stim[r]);
      end
    end
  endtask

  task automatic test_backpressure();
    cfg_birth = 9'h008; cfg_survive = 9'h00C; cfg_wrap = 1'b1;
    for (int it = 0; it < 2; it++) begin
      for (int r = 0; r < H; r++) stim[r] = W'($urandom);
      load_stim(0, 0);
      do_start(2);
      wait_valid();
      collect(50);
      model_run(2, 9'h008, 9'h00C, 1'b1);
      for (int r = 0; r < H; r++) begin
        total++;
        if (got_rows[r] !== mgrid[r]) begin
          bad++;
          $display("FAIL bp_row row=%0d got=%h exp=%h", r, got_rows[r], mgrid[r]);
        end
      end
      total++;
      if (got_last !== 8'h80) begin
        bad++;
        $display("FAIL bp_last got=%b exp=10000000", got_last);
      end
      total++;
      if (!got_stable || got_early_done || got_lr_bad || got_timeout || !got_done) begin
        bad++;
        $display("FAIL bp_flags stable=%b early_done=%b lr_bad=%b timeout=%b done=%b exp=1_0_0_0_1",
                 got_stable, got_early_done, got_lr_bad, got_timeout, got_done);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    for (int r = 0; r < H; r++) stim[r] = W'($urandom) | 8'h01;
    load_stim(0, 0);
    do_start(3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset got=%b%b exp=00", busy, bus.out_valid);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int r = 0; r < H; r++) mgrid[r] = '0;
    mload_ptr = 0;
    do_start(0);
    wait_valid();
    collect(100);
    for (int r = 0; r < H; r++) begin
      total++;
      if (got_rows[r] !== 8'h00) begin
        bad++;
        $display("FAIL midrun_zero row=%0d got=%h exp=00", r, got_rows[r]);
      end
    end
  endtask

  task automatic test_masks();
    cfg_birth = 9'h000; cfg_survive = 9'h000; cfg_wrap = 1'b1;
    for (int r = 0; r < H; r++) stim[r] = W'($urandom);
    load_stim(0, 0);
    do_start(1);
    wait_valid();
    collect(100);
    model_run(1, 9'h000, 9'h000, 1'b1);
    for (int r = 0; r < H; r++) begin
      total++;
      if (got_rows[r] !== 8'h00) begin
        bad++;
        $display("FAIL masks_zero row=%0d got=%h exp=00", r, got_rows[r]);
      end
    end
    // HighLife: dead cell (3,3) sees exactly six live neighbours.
    cfg_birth = 9'h048; cfg_survive = 9'h00C; cfg_wrap = 1'b0;
    for (int r = 0; r < H; r++) stim[r] = 8'h00;
    stim[2] = 8'h1C; stim[3] = 8'h14; stim[4] = 8'h04;
    load_stim(0, 0);
    do_start(1);
    wait_valid();
    collect(100);
    model_run(1, 9'h048, 9'h00C, 1'b0);
    total++;
    if (got_rows[3][3] !== 1'b1) begin
      bad++;
      $display("FAIL highlife_birth got=%b exp=1", got_rows[3][3]);
    end
    for (int r = 0; r < H; r++) begin
      total++;
      if (got_rows[r] !== mgrid[r]) begin
        bad++;
        $display("FAIL highlife_row row=%0d got=%h exp=%h", r, got_rows[r], mgrid[r]);
      end
    end
    // A start pulse while busy must not change the generation count.
    cfg_birth = 9'h008; cfg_survive = 9'h00C;
    do_start(2);
    got_k = 0;
    while (got_k < 2000) begin
      @(negedge clk);
      if (got_k == 3) begin start = 1'b1; gen_count = 8'd5; end
      else start = 1'b0;
      if (bus.out_valid) break;
      got_k++;
    end
    start = 1'b0;
    total++;
    if (got_k !== 2 * H) begin
      bad++;
      $display("FAIL busy_start_latency got=%0d exp=%0d", got_k, 2 * H);
    end
    collect(100);
    model_run(2, 9'h008, 9'h00C, 1'b0);
    for (int r = 0; r < H; r++) begin
      total++;
      if (got_rows[r] !== mgrid[r]) begin
        bad++;
        $display("FAIL busy_start_row row=%0d got=%h exp=%h", r, got_rows[r], mgrid[r]);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] b, s;
    bit         wr;
    int         gens;
    for (int it = 0; it < 8; it++) begin
      b    = ($urandom_range(1) == 0) ? 9'h008 : 9'($urandom);
      s    = ($urandom_range(1) == 0) ? 9'h00C : 9'($urandom);
      wr   = 1'($urandom_range(1));
      gens = $urandom_range(3, 1);
      cfg_birth = b; cfg_survive = s; cfg_wrap = wr;
      if (it == 0 || $urandom_range(1) == 1) begin
        for (int r = 0; r < H; r++) stim[r] = W'($urandom);
        load_stim(0, 0);
      end
      do_start(gens);
      cfg_birth = 9'($urandom); cfg_survive = 9'($urandom); cfg_wrap = ~wr;
      wait_valid();
      total++;
      if (got_k !== gens * H) begin
        bad++;
        $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, got_k, gens * H);
      end
      collect($urandom_range(100, 30));
      model_run(gens, b, s, wr);
      for (int r = 0; r < H; r++) begin
        total++;
        if (got_rows[r] !== mgrid[r]) begin
          bad++;
          $display("FAIL rand_row it=%0d row=%0d got=%h exp=%h", it, r, got_rows[r], mgrid[r]);
        end
      end
    end
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_row   = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_blinker();
    test_edges();
    test_gen0();
    test_backpressure();
    test_reset_mid_run();
    test_masks();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
